// File: rtl/shifter_pkg.sv
// Shared constants and helpers for the pipelined barrel shifter.
// Contents: mode/direction encodings, log2 helper used for parameter checks.
package shifter_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ROT = 2'b00;
  localparam logic [MODE_W-1:0] MODE_LSH = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ASH = 2'b10;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Ceiling log2; used to check that M matches N and to locate a stage's amt bit.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'(1) << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered slice of the barrel shifter: shifts/rotates by SHIFT when
// the amt bit for this stage is set, otherwise passes data through.
// Ports: clk, rst (async, active-high), en_i (advance; hold when 0),
//        valid/data/lr/mode/amt/fill (+carry with SHIFT_CARRY_EN) in and out.
// Optional: SHIFT_CARRY_EN adds carry_i/carry_o tracking the last bit shifted out.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned SHIFT = 1,
  parameter int unsigned M     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [N-1:0]      data_i,
  input  logic              lr_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [M-1:0]      amt_i,
  input  logic              fill_i,
`ifdef SHIFT_CARRY_EN
  input  logic              carry_i,
  output logic              carry_o,
`endif
  output logic              valid_o,
  output logic [N-1:0]      data_o,
  output logic              lr_o,
  output logic [MODE_W-1:0] mode_o,
  output logic [M-1:0]      amt_o,
  output logic              fill_o
);

  localparam int unsigned BIT = clog2_f(SHIFT);

  logic              valid_q;
  logic [N-1:0]      data_q, data_d;
  logic              lr_q;
  logic [MODE_W-1:0] mode_q;
  logic [M-1:0]      amt_q;
  logic              fill_q;
  logic              sel;
  logic              rotate;

  assign sel    = amt_i[BIT];
  // Reserved mode 2'b11 behaves as rotate.
  assign rotate = (mode_i != MODE_LSH) && (mode_i != MODE_ASH);

`ifdef SHIFT_CARRY_EN
  logic carry_q, carry_d;
`endif

  // Mux slice; stages run in increasing SHIFT order, so the last active
  // stage's outgoing edge bit is the overall last bit shifted out.
  always_comb begin
    data_d = data_i;
`ifdef SHIFT_CARRY_EN
    carry_d = carry_i;
`endif
    if (sel) begin
      if (lr_i == DIR_LEFT) begin
        data_d = rotate ? {data_i[N-SHIFT-1:0], data_i[N-1:N-SHIFT]}
                        : {data_i[N-SHIFT-1:0], {SHIFT{1'b0}}};
`ifdef SHIFT_CARRY_EN
        carry_d = data_i[N-SHIFT];
`endif
      end else begin
        data_d = rotate ? {data_i[SHIFT-1:0], data_i[N-1:SHIFT]}
                        : {{SHIFT{fill_i}}, data_i[N-1:SHIFT]};
`ifdef SHIFT_CARRY_EN
        carry_d = data_i[SHIFT-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      lr_q    <= 1'b0;
      mode_q  <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
`ifdef SHIFT_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      lr_q    <= lr_i;
      mode_q  <= mode_i;
      amt_q   <= amt_i;
      fill_q  <= fill_i;
`ifdef SHIFT_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign lr_o    = lr_q;
  assign mode_o  = mode_q;
  assign amt_o   = amt_q;
  assign fill_o  = fill_q;
`ifdef SHIFT_CARRY_EN
  assign carry_o = carry_q;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined rotate / logical / arithmetic barrel shifter, M stages,
// one operation per clock with valid/ready on both sides.
// Ports: clk, rst (async, active-high); in_valid/in_ready, num, amt, lr, mode;
//        out_valid/out_ready, out (+carry_out with SHIFT_CARRY_EN).
// Optional: define SHIFT_CARRY_EN for carry_out (last bit shifted out).
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      num,
  input  logic [M-1:0]      amt,
  input  logic              lr,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SHIFT_CARRY_EN
  output logic              carry_out,
`endif
  output logic [N-1:0]      out
);

  if (M != clog2_f(N) || N < 4 || (32'(1) << M) != N) begin : g_param_err
    $error("pipelined_barrel_shifter: N must be a power of two >= 4 and M = log2(N)");
  end

  // Index 0 is the pipeline input; index k+1 is the output of stage k.
  logic              s_valid [M+1];
  logic [N-1:0]      s_data  [M+1];
  logic              s_lr    [M+1];
  logic [MODE_W-1:0] s_mode  [M+1];
  logic [M-1:0]      s_amt   [M+1];
  logic              s_fill  [M+1];
`ifdef SHIFT_CARRY_EN
  logic              s_carry [M+1];
`endif
  logic              adv_c;

  // Whole pipe advances together; a full output slot with no taker stalls all.
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  assign s_valid[0] = in_valid;
  assign s_data[0]  = num;
  assign s_lr[0]    = lr;
  assign s_mode[0]  = mode;
  assign s_amt[0]   = amt;
  // Sign is captured at acceptance; only arithmetic right fills with it.
  assign s_fill[0]  = (mode == MODE_ASH) && (lr == DIR_RIGHT) && num[N-1];
`ifdef SHIFT_CARRY_EN
  assign s_carry[0] = 1'b0;
`endif

  for (genvar k = 0; k < int'(M); k++) begin : g_stage
    shift_stage #(
      .N    (N),
      .SHIFT(32'(1) << k),
      .M    (M)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (adv_c),
      .valid_i(s_valid[k]),
      .data_i (s_data[k]),
      .lr_i   (s_lr[k]),
      .mode_i (s_mode[k]),
      .amt_i  (s_amt[k]),
      .fill_i (s_fill[k]),
`ifdef SHIFT_CARRY_EN
      .carry_i(s_carry[k]),
      .carry_o(s_carry[k+1]),
`endif
      .valid_o(s_valid[k+1]),
      .data_o (s_data[k+1]),
      .lr_o   (s_lr[k+1]),
      .mode_o (s_mode[k+1]),
      .amt_o  (s_amt[k+1]),
      .fill_o (s_fill[k+1])
    );
  end

  assign out_valid = s_valid[M];
  assign out       = s_data[M];
`ifdef SHIFT_CARRY_EN
  assign carry_out = s_carry[M];
`endif

  // Control carried out of the last stage has no consumer.
  logic unused_tail;
  assign unused_tail = ^{s_lr[M], s_mode[M], s_amt[M], s_fill[M]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

  localparam int unsigned N = 16;
  localparam int unsigned M = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] num;
  logic [M-1:0] amt;
  logic         lr;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
`ifdef SHIFT_CARRY_EN
  logic         carry_out;
`endif

  pipelined_barrel_shifter #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num      (num),
    .amt      (amt),
    .lr       (lr),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SHIFT_CARRY_EN
    .carry_out(carry_out),
`endif
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] d;
    logic         c;
    int           due;
    bit           chk_lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   nostall = 1'b1;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Reference: rotate via a doubled word, shifts via native operators.
  function automatic void model(input logic [N-1:0] n, input int a, input logic l,
                                input logic [1:0] md, output logic [N-1:0] r, output logic c);
    logic [2*N-1:0] dd;
    logic [2*N-1:0] t;
    logic signed [N-1:0] sn;
    dd = {n, n};
    sn = n;
    if (md == 2'b01 || md == 2'b10) begin
      if (l) r = n << a;
      else if (md == 2'b10) r = sn >>> a;
      else r = n >> a;
    end else begin
      if (l) begin t = dd << a; r = t[2*N-1:N]; end
      else   begin t = dd >> a; r = t[N-1:0];   end
    end
    if (a == 0) c = 1'b0;
    else if (l) c = n[N-a];
    else c = n[a-1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_data", 32'(out), 32'(q[0].d));
`ifdef SHIFT_CARRY_EN
        check("carry_out", 32'(carry_out), 32'(q[0].c));
`endif
        if (q[0].chk_lat) check("latency", 32'(cyc), 32'(q[0].due));
        if (out_ready) void'(q.pop_front());
        else check("in_ready_stall", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic issue(input logic [N-1:0] n, input logic [M-1:0] a,
                       input logic l, input logic [1:0] md);
    exp_t e;
    logic [N-1:0] r;
    logic c;
    bit done;
    bit first;
    done = 1'b0;
    first = 1'b1;
    in_valid = 1'b1; num = n; amt = a; lr = l; mode = md;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (first && nostall) check("in_ready_nostall", 32'(in_ready), 32'd1);
      first = 1'b0;
      if (in_ready) begin
        model(n, int'(a), l, md, r, c);
        e.d = r; e.c = c; e.due = cyc + int'(M); e.chk_lat = nostall;
        q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue_rand();
    issue(N'($urandom), M'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; num = '0; amt = '0; lr = 1'b0; mode = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases, back-to-back.
    issue(16'hFF00, 4'd4, 1'b0, 2'b00);
    issue(16'h8000, 4'd15, 1'b0, 2'b10);
    issue(16'h8000, 4'd15, 1'b0, 2'b01);
    issue(16'h00FF, 4'd8, 1'b1, 2'b01);
    issue(16'h00FF, 4'd8, 1'b1, 2'b10);
    issue(16'h8001, 4'd1, 1'b1, 2'b00);
    issue(16'h0001, 4'd1, 1'b0, 2'b01);
    issue(16'h8000, 4'd1, 1'b1, 2'b01);
    issue(16'hA5C3, 4'd0, 1'b0, 2'b10);
    issue(16'hA5C3, 4'd0, 1'b1, 2'b11);
    issue(16'h7FFF, 4'd3, 1'b0, 2'b10);
    // Sweep rotate right and arithmetic right over every amount.
    for (int a = 0; a < int'(N); a++) issue(16'hC3A5, M'(a), 1'b0, 2'b00);
    for (int a = 0; a < int'(N); a++) issue(16'h9234, M'(a), 1'b0, 2'b10);
    // Back-to-back random.
    for (int i = 0; i < 32; i++) issue_rand();
    drain();

    // Backpressure: 4 in flight, output blocked for 6 cycles.
    nostall = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_rand();
    repeat (6) @(posedge clk);
    #1;
    check("bp_held_count", 32'(q.size()), 32'd4);
    out_ready = 1'b1;
    drain();

    // Random backpressure with random ops.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) issue_rand();
    rand_rdy = 1'b0;
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with operations in flight.
    nostall = 1'b1;
    for (int i = 0; i < 5; i++) issue(16'hF00F, 4'd0, 1'b0, 2'b00);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(16'h1234, 4'd5, 1'b1, 2'b00);
    issue(16'hFFFF, 4'd7, 1'b0, 2'b01);
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined multi-mode barrel shifter. It supports rotate, logical shift and arithmetic shift in both directions. The data path is split into log2(N) registered mux stages (one stage per bit of amt), with valid/ready handshakes on input and output. It sits between an upstream producer and a downstream consumer in the datapath and sustains one operation per clock.

Parameters:
N, 16, data width in bits (power of two, >= 4)
M, 4, shift-amount width; must equal log2(N); one pipeline stage per bit

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  block accepts the operation this cycle
num  input  N  operand
amt  input  M  shift/rotate amount, 0..N-1
lr  input  1  direction: 0 = right, 1 = left
mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 reserved (treated as rotate)
out_valid  output  1  result is valid
out_ready  input  1  downstream accepts the result
out  output  N  result

Behaviour:
- Clocking and reset: one clock (clk). rst is asynchronous and active-high. On rst, every stage valid bit, out_valid, out, and all stage data/control registers go to 0 immediately. in_ready is combinational and reads 1 while reset is held.
- Pipeline: stage k (k = 0..M-1) registers its data after shifting by 2^k when amt[k]=1, otherwise it passes the data through. Each stage also carries lr, mode, the remaining amt bits, the fill bit and a valid bit.
- Latency: exactly M cycles from the accepting edge (in_valid & in_ready) to out_valid=1 with the matching out. Throughput is 1 per cycle with no stall.
- Stall rule: adv = !out_valid | out_ready, and in_ready = adv. When adv=0, all stages hold their contents.
- Bubbles are not compressed. An empty slot advances only when adv=1.
- Accepting a new input in the same cycle the output is consumed is legal and does not cause a stall.
- Fill rules:
  - Rotate: the bits that leave one end wrap around to the other end.
  - Logical: vacated bits are filled with 0.
  - Arithmetic right: vacated bits are filled with num[N-1], captured at acceptance.
  - Arithmetic left: identical to logical left.
- amt=0: out=num in every mode and direction.
- out and out_valid are held stable while out_valid=1 and out_ready=0. in_ready=0 in that state.
- in_valid while in_ready=0 is ignored. The source must hold num/amt/lr/mode until in_ready=1.
- rst asserted mid-operation flushes all in-flight operations. No result is produced for them.

Optional Feature:
Macro SHIFT_CARRY_EN.
- With SHIFT_CARRY_EN defined: an extra output port carry_out (1 bit) is aligned with out and out_valid. Its value is the last bit shifted or rotated out:
  - right: num[amt-1]
  - left: num[N-amt]
  - amt=0: 0
  - carry_out resets to 0 and is held under stall like out.
- Without the macro: the port and its pipeline registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Package shifter_pkg holds:
  - mode constants MODE_ROT=2'b00, MODE_LSH=2'b01, MODE_ASH=2'b10
  - direction constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1
  - a helper function for log2 parameter checking
- Sub-module shift_stage (parameters N, SHIFT) implements one registered 2^k mux slice with its valid/control/fill/carry registers and a hold enable. The top module generates M instances of it and the adv logic.

Test Plan:
- N=16, rotate right, num=16'hFF00, amt=4 -> out=16'h0FF0 exactly 4 cycles after acceptance; sweep amt=0..15 and check against a rotate model.
- Arithmetic right: num=16'h8000, amt=15 -> 16'hFFFF. Logical right, same inputs -> 16'h0001. Logical/arithmetic left: num=16'h00FF, amt=8 -> 16'hFF00. Rotate left: num=16'h8001, amt=1 -> 16'h0003.
- Back-to-back: 32 random operations on consecutive cycles with out_ready=1 -> in_ready stays 1, results arrive in order one per cycle, all match the model.
- Backpressure: out_ready=0 for 6 cycles with 4 operations in flight -> out is held, in_ready=0, no loss or duplication; release -> remaining results drain in order.
- Reset mid-flight: assert rst with 3 operations in the pipe -> out_valid=0 and out=0 immediately; after release the first new operation appears exactly 4 cycles later.
- With SHIFT_CARRY_EN: num=16'h0001, logical right, amt=1 -> out=16'h0000, carry_out=1. num=16'h8000, logical left, amt=1 -> carry_out=1. amt=0 -> carry_out=0.
